// File: rtl/adder_pkg.sv
// Shared constants and configuration helpers for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // True when the stage count is legal for the given width.
  function automatic bit stages_divide(input int width, input int stages);
    if (width < 1 || stages < 1) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-pipelined chunk of the adder: adds the lowest unconsumed operand
// chunk, skews the remaining operand bits forward and holds a valid/ready slice.
module adder_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int UPPER = 16,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_carry,
  output logic             out_ovf
);

  // UPPER counts operand bits still unconsumed on entry; the chunk produced
  // here lands just above the DONE bits already finished upstream.
  localparam int DONE = WIDTH - UPPER;

  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  logic             valid_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             ovf_q;

  // Chunk add; operands arrive shifted so the chunk to consume is at bit 0.
  // Overflow is carry-into-MSB xor carry-out, only meaningful in the last chunk.
  always_comb begin
    chunk_res = {1'b0, in_a[CHUNK-1:0]} + {1'b0, in_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, in_carry};
    sum_d     = in_sum | (WIDTH'(chunk_res[CHUNK-1:0]) << DONE);
    ovf_d     = LAST ? (in_a[CHUNK-1] ^ in_b[CHUNK-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK])
                     : 1'b0;
  end

  // A slice loads whenever it is empty or its contents move on this cycle,
  // so bubbles collapse even while the output is stalled.
  assign in_ready = !valid_q || out_ready;

  // Register slice: valid always follows on load, data only for real operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        a_q     <= in_a >> CHUNK;
        b_q     <= in_b >> CHUNK;
        carry_q <= chunk_res[CHUNK];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit split into STAGES carry-pipelined chunks with a
// valid/ready stream on both sides; one op per cycle, latency STAGES cycles.
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; valid never depends on ready, and ready on the input side is a
// combinational function of out_ready and the stage occupancy.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (!stages_divide(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH exactly");
  end

  localparam int CHUNK = WIDTH / STAGES;

  // Index k carries the signals between stage k-1 and stage k.
  logic [WIDTH-1:0] sum_bus   [STAGES+1];
  logic [WIDTH-1:0] a_bus     [STAGES+1];
  logic [WIDTH-1:0] b_bus     [STAGES+1];
  logic             carry_bus [STAGES+1];
  logic             valid_bus [STAGES+1];
  logic             ready_bus [STAGES+1];
  logic [STAGES-1:0] ovf_vec;

  // Subtract is add of the inverted operand; cin supplies the +1 for A-B.
  assign sum_bus[0]        = '0;
  assign a_bus[0]          = a;
  assign b_bus[0]          = (mode == MODE_SUB) ? ~b : b;
  assign carry_bus[0]      = cin;
  assign valid_bus[0]      = in_valid;
  assign in_ready          = ready_bus[0];
  assign ready_bus[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .UPPER (WIDTH - k * CHUNK),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_bus[k]),
      .in_ready  (ready_bus[k]),
      .in_sum    (sum_bus[k]),
      .in_a      (a_bus[k]),
      .in_b      (b_bus[k]),
      .in_carry  (carry_bus[k]),
      .out_valid (valid_bus[k+1]),
      .out_ready (ready_bus[k+1]),
      .out_sum   (sum_bus[k+1]),
      .out_a     (a_bus[k+1]),
      .out_b     (b_bus[k+1]),
      .out_carry (carry_bus[k+1]),
      .out_ovf   (ovf_vec[k])
    );
  end

  assign out_valid = valid_bus[STAGES];
  assign sum       = sum_bus[STAGES];
  assign cout      = carry_bus[STAGES];
  assign ovf       = ovf_vec[STAGES-1];

  // The fully consumed operand registers and non-final overflow bits are
  // constant zero; fold them into one sink so they are visibly intentional.
  logic unused_tail;
  assign unused_tail = ^{a_bus[STAGES], b_bus[STAGES], ovf_vec};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 16-bit/4-stage instance and an 8-bit/1-stage
// instance, checked against an integer-arithmetic reference model.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // wide instance: WIDTH=16, STAGES=4
  logic        w_in_valid, w_in_ready, w_cin, w_mode, w_out_valid, w_out_ready, w_cout, w_ovf;
  logic [15:0] w_a, w_b, w_sum;
  // narrow instance: WIDTH=8, STAGES=1
  logic        n_in_valid, n_in_ready, n_cin, n_mode, n_out_valid, n_out_ready, n_cout, n_ovf;
  logic [7:0]  n_a, n_b, n_sum;

  logic [17:0] exp_q[$];

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin), .mode(w_mode), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .cin(n_cin), .mode(n_mode), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .ovf(n_ovf)
  );

  // Reference: {ovf, cout, sum} from plain integer arithmetic on w-bit values.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic m);
    int mask, half, ua, ub, full, sa, sb, sr;
    logic ov, co;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(a) & mask;
    ub   = m ? (~int'(b)) & mask : int'(b) & mask;
    full = ua + ub + int'(c);
    sa   = (ua >= half) ? ua - (1 << w) : ua;
    sb   = (ub >= half) ? ub - (1 << w) : ub;
    sr   = sa + sb + int'(c);
    ov   = (sr >= half) || (sr < -half);
    co   = ((full >> w) & 1) != 0;
    return {ov, co, 16'(full & mask)};
  endfunction

  function automatic logic [17:0] w_obs();
    return {w_ovf, w_cout, w_sum};
  endfunction

  function automatic logic [17:0] n_obs();
    return {n_ovf, n_cout, 8'h00, n_sum};
  endfunction

  // Driver tasks: called just after a falling edge; settle before sampling.
  task automatic drive_w(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic m, input logic ordy);
    w_in_valid = v; w_a = a; w_b = b; w_cin = c; w_mode = m; w_out_ready = ordy;
    #1;
  endtask

  task automatic drive_n(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic m, input logic ordy);
    n_in_valid = v; n_a = a; n_b = b; n_cin = c; n_mode = m; n_out_ready = ordy;
    #1;
  endtask

  // Issue one op into an empty wide pipe; report cycles until out_valid (-1 on timeout).
  task automatic run_single_w(input logic [15:0] a, input logic [15:0] b, input logic c,
                              input logic m, output int lat, output logic [17:0] got);
    lat = -1;
    got = '0;
    @(negedge clk);
    drive_w(1'b1, a, b, c, m, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive_w(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (w_out_valid) begin
        lat = i;
        got = w_obs();
        break;
      end
    end
  endtask

  task automatic run_single_n(input logic [7:0] a, input logic [7:0] b, input logic c,
                              input logic m, output int lat, output logic [17:0] got);
    lat = -1;
    got = '0;
    @(negedge clk);
    drive_n(1'b1, a, b, c, m, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive_n(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
      if (n_out_valid) begin
        lat = i;
        got = n_obs();
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_w_out_valid got=%b want=0", w_out_valid); end
    checks++; if (w_obs() !== 18'h0) begin errors++; $display("FAIL reset_w_outputs got=%h want=0", w_obs()); end
    checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL reset_w_in_ready got=%b want=1", w_in_ready); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL reset_n_out_valid got=%b want=0", n_out_valid); end
    checks++; if (n_obs() !== 18'h0) begin errors++; $display("FAIL reset_n_outputs got=%h want=0", n_obs()); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_carry;
    int lat;
    logic [17:0] got;
    run_single_w(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, got);
    checks++; if (lat != 4) begin errors++; $display("FAIL add_carry_latency got=%0d want=4", lat); end
    checks++; if (got !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL add_carry_value got=%h want=%h", got, {1'b0, 1'b1, 16'h0000}); end
  endtask

  task automatic test_sub_overflow;
    int lat;
    logic [17:0] got;
    run_single_w(16'h8000, 16'h0001, 1'b1, 1'b1, lat, got);
    checks++; if (lat != 4) begin errors++; $display("FAIL sub_ovf_latency got=%0d want=4", lat); end
    checks++; if (got !== {1'b1, 1'b1, 16'h7FFF}) begin errors++; $display("FAIL sub_ovf_value got=%h want=%h", got, {1'b1, 1'b1, 16'h7FFF}); end
    run_single_w(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, got);
    checks++; if (got !== {1'b1, 1'b0, 16'h8000}) begin errors++; $display("FAIL add_ovf_value got=%h want=%h", got, {1'b1, 1'b0, 16'h8000}); end
  endtask

  task automatic test_back_to_back;
    int first = -1, last = -1, n_out = 0;
    logic [15:0] ra, rb;
    logic rc, rm;
    logic [17:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
      @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      drive_w(cyc < 8, ra, rb, rc, rm, 1'b1);
      if (cyc < 8) begin
        checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, w_in_ready); end
      end
      if (w_in_valid && w_in_ready) exp_q.push_back(model(16, ra, rb, rc, rm));
      if (w_out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_out++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++; if (w_obs() !== e) begin errors++; $display("FAIL b2b_result cyc=%0d got=%h want=%h", cyc, w_obs(), e); end
      end
    end
    checks++; if (first != 4) begin errors++; $display("FAIL b2b_first_valid got=%0d want=4", first); end
    checks++; if (last != 11 || n_out != 8) begin errors++; $display("FAIL b2b_run got_last=%0d got_n=%0d want_last=11 want_n=8", last, n_out); end
  endtask

  task automatic test_stall;
    int n_in = 0, n_out = 0;
    logic [15:0] ra, rb;
    logic rc, rm, ordy;
    logic [17:0] held, e;
    exp_q.delete();
    held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      ordy = (cyc >= 7);
      drive_w(cyc <= 10, ra, rb, rc, rm, ordy);
      if (cyc <= 3) begin
        checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready cyc=%0d got=%b want=1", cyc, w_in_ready); end
      end
      if (cyc >= 4 && cyc <= 6) begin
        if (cyc == 4) held = (exp_q.size() > 0) ? exp_q[0] : 18'h3FFFF;
        checks++; if (w_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, w_in_ready); end
        checks++; if (w_out_valid !== 1'b1 || w_obs() !== held) begin errors++; $display("FAIL stall_hold cyc=%0d got_v=%b got=%h want=%h", cyc, w_out_valid, w_obs(), held); end
      end
      if (w_in_valid && w_in_ready) begin
        exp_q.push_back(model(16, ra, rb, rc, rm));
        n_in++;
      end
      if (w_out_valid && w_out_ready) begin
        n_out++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++; if (w_obs() !== e) begin errors++; $display("FAIL stall_drain cyc=%0d got=%h want=%h", cyc, w_obs(), e); end
      end
    end
    checks++; if (n_in != 8 || n_out != 8 || exp_q.size() != 0) begin errors++; $display("FAIL stall_count got_in=%0d got_out=%0d left=%0d want=8/8/0", n_in, n_out, exp_q.size()); end
  endtask

  task automatic test_random_flow;
    logic [15:0] ra, rb;
    logic rc, rm, rv, ordy, stalled;
    logic [17:0] prev, e;
    exp_q.delete();
    stalled = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      rv = (cyc < 300) && ($urandom_range(0, 9) < 7);
      ordy = (cyc >= 300) || ($urandom_range(0, 9) < 6);
      drive_w(rv, ra, rb, rc, rm, ordy);
      if (stalled) begin
        checks++; if (w_out_valid !== 1'b1 || w_obs() !== prev) begin errors++; $display("FAIL random_hold cyc=%0d got_v=%b got=%h want=%h", cyc, w_out_valid, w_obs(), prev); end
      end
      stalled = w_out_valid && !w_out_ready;
      prev = w_obs();
      if (w_in_valid && w_in_ready) exp_q.push_back(model(16, ra, rb, rc, rm));
      if (w_out_valid && w_out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++; if (w_obs() !== e) begin errors++; $display("FAIL random_result cyc=%0d got=%h want=%h", cyc, w_obs(), e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      case (cyc)
        0: drive_w(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        1: drive_w(1'b1, 16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b1);
        2: drive_w(1'b1, 16'hAAAA, 16'h1111, 1'b1, 1'b1, 1'b1);
        default: drive_w(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      endcase
    end
    checks++; if (w_out_valid !== 1'b1 || w_sum !== 16'h5555) begin errors++; $display("FAIL midrst_before got_v=%b got=%h want_v=1 want=5555", w_out_valid, w_sum); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", w_out_valid); end
    checks++; if (w_obs() !== 18'h0) begin errors++; $display("FAIL midrst_outputs got=%h want=0", w_obs()); end
    checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", w_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      drive_w(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc=%0d got=%b want=0", cyc, w_out_valid); end
    end
  endtask

  task automatic test_narrow;
    int lat;
    logic [17:0] got, e;
    logic [7:0] ra, rb;
    logic rc, rm;
    logic [7:0] b_edge [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    run_single_n(8'h7F, 8'h01, 1'b0, 1'b0, lat, got);
    checks++; if (lat != 1) begin errors++; $display("FAIL narrow_latency got=%0d want=1", lat); end
    checks++; if (got !== {1'b1, 1'b0, 16'h0080}) begin errors++; $display("FAIL narrow_ovf_value got=%h want=%h", got, {1'b1, 1'b0, 16'h0080}); end
    exp_q.delete();
    // every a against edge values of b, all mode/carry combinations, then
    // a checkerboard half of the full a x b plane with random mode/carry
    for (int i = 0; i < 5120 + 32768 + 2; i++) begin
      @(negedge clk);
      if (i < 5120) begin
        ra = 8'(i / 20); rb = b_edge[(i / 4) % 5]; rm = 1'(i >> 1); rc = 1'(i);
      end else begin
        ra = 8'((i - 5120) >> 7);
        rb = 8'((((i - 5120) & 127) << 1) | ((i - 5120) >> 7 & 1));
        rm = 1'($urandom); rc = 1'($urandom);
      end
      drive_n(i < 5120 + 32768, ra, rb, rc, rm, 1'b1);
      if (n_in_valid && n_in_ready) exp_q.push_back(model(8, {8'h00, ra}, {8'h00, rb}, rc, rm));
      if (n_out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++; if (n_obs() !== e) begin errors++; $display("FAIL narrow_sweep i=%0d got=%h want=%h", i, n_obs(), e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL narrow_drain left=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_mode = 1'b0; w_out_ready = 1'b0;
    n_in_valid = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_mode = 1'b0; n_out_ready = 1'b0;
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_back_to_back();
    test_stall();
    test_random_flow();
    test_reset_midstream();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
